ps2_key_tracker: RTL and testbench

- Upstream feeder for the hex seven-segment digit decoders on the board display.
- Receives raw PS/2 keyboard frames, tracks make/break codes and counts key presses.
- Presents registered 4-bit nibbles plus enables that drive four decoder instances:
  - scan code high and low digits, blanked when no key is held;
  - two-digit BCD press count, always shown.

---
 rtl/ps2_key_tracker.sv | 167 ++++++++++++++++
 tb/tb_ps2_key_tracker.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard frame receiver and key make/break tracker.
// Drives registered nibbles and enables for four hex digit decoders.
module ps2_key_tracker #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] code_hi,
  output logic [3:0] code_lo,
  output logic       code_en,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic       frame_err
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHeld   = 2'd1;
  localparam logic [1:0] StBreakH = 2'd2;
  localparam logic [1:0] StBreakI = 2'd3;

  logic [2:0]       clk_sync_q, dat_sync_q;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  logic [1:0]       state_q, state_d;
  logic [7:0]       code_q, code_d;
  logic             code_en_q, code_en_d;
  logic [3:0]       tens_q, tens_d, ones_q, ones_d;
  logic             fall, bit_in, inc;

  // Older synchronised stage high and newer stage low marks a falling edge.
  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_in = dat_sync_q[1];

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tmo_d        = tmo_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    if (fall) begin
      tmo_d = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        // shift_q holds {parity, data[7:0], start}; bit_in is the stop bit.
        if (!shift_q[0] && bit_in && (^shift_q[9:1])) begin
          byte_valid_d = 1'b1;
          byte_d       = shift_q[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d   = {bit_in, shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (tmo_q == CNT_W'(TIMEOUT_CYC)) begin
        bit_cnt_d = 4'd0;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    code_en_d = code_en_q;
    inc       = 1'b0;
    if (byte_valid_q && byte_q != 8'hE0) begin
      unique case (state_q)
        StIdle: begin
          if (byte_q == 8'hF0) begin
            state_d = StBreakI;
          end else begin
            code_d    = byte_q;
            code_en_d = 1'b1;
            inc       = 1'b1;
            state_d   = StHeld;
          end
        end
        StHeld: begin
          if (byte_q == 8'hF0) begin
            state_d = StBreakH;
          end else if (byte_q != code_q) begin
            code_d = byte_q;
            inc    = 1'b1;
          end
        end
        StBreakH: begin
          if (byte_q == code_q) begin
            code_en_d = 1'b0;
            state_d   = StIdle;
          end else begin
            state_d = StHeld;
          end
        end
        StBreakI: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (inc) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync_q   <= '0;
      dat_sync_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tmo_q        <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      state_q      <= StIdle;
      code_q       <= '0;
      code_en_q    <= 1'b0;
      tens_q       <= '0;
      ones_q       <= '0;
    end else begin
      clk_sync_q   <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q   <= {dat_sync_q[1:0], ps2_data};
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tmo_q        <= tmo_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      state_q      <= state_d;
      code_q       <= code_d;
      code_en_q    <= code_en_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
    end
  end

  assign code_hi   = code_q[7:4];
  assign code_lo   = code_q[3:0];
  assign code_en   = code_en_q;
  assign cnt_tens  = tens_q;
  assign cnt_ones  = ones_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: stimulus queues expected display states,
// a monitor pops one entry each time the registered outputs change.
module tb_ps2_key_tracker;

  localparam int unsigned TMO  = 64;
  localparam int          HALF = 5;
  localparam int          GAP  = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] code_hi, code_lo, cnt_tens, cnt_ones;
  logic       code_en, frame_err;

  ps2_key_tracker #(
    .TIMEOUT_CYC(TMO),
    .CNT_W      (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code_hi  (code_hi),
    .code_lo  (code_lo),
    .code_en  (code_en),
    .cnt_tens (cnt_tens),
    .cnt_ones (cnt_ones),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [17:0] exp_q[$];
  logic        exp_ferr = 1'b0;
  logic [17:0] cur, prev, e;

  // {code[7:0], code_en, tens, ones, frame_err}
  assign cur = {code_hi, code_lo, code_en, cnt_tens, cnt_ones, frame_err};

  function automatic logic [17:0] pack(input logic [7:0] code, input logic en, input int cnt,
                                       input logic ferr);
    return {code, en, 4'(cnt / 10), 4'(cnt % 10), ferr};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev = cur;
    end else begin
      if (cur !== prev) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output got=%h required=no change", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL output_update got=%h required=%h", cur, e);
          end
        end
      end
      prev = cur;
    end
  end

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] b, input logic good_par);
    return {1'b1, good_par ? ~^b : ^b, b, 1'b0};
  endfunction

  // Queue the expected display (if it changes), then transmit the byte.
  task automatic key(input logic [7:0] b, input logic ch, input logic [7:0] code,
                     input logic en, input int cnt);
    if (ch) exp_q.push_back(pack(code, en, cnt, exp_ferr));
    send_bits(frame(b, 1'b1), 11);
    repeat (GAP) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", cur, 18'h0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // First press
    key(8'h1C, 1, 8'h1C, 1, 1);
    // Typematic repeats, then release
    key(8'h1C, 0, 8'h00, 0, 0);
    key(8'h1C, 0, 8'h00, 0, 0);
    key(8'h1C, 0, 8'h00, 0, 0);
    key(8'hF0, 0, 8'h00, 0, 0);
    key(8'h1C, 1, 8'h1C, 0, 1);
    // Rollover, release of non-held key, then release of held key
    key(8'h1C, 1, 8'h1C, 1, 2);
    key(8'hE0, 0, 8'h00, 0, 0);
    key(8'h32, 1, 8'h32, 1, 3);
    key(8'hF0, 0, 8'h00, 0, 0);
    key(8'h1C, 0, 8'h00, 0, 0);
    key(8'hF0, 0, 8'h00, 0, 0);
    key(8'h32, 1, 8'h32, 0, 3);
    // Prefix ignored in IDLE
    key(8'hE0, 0, 8'h00, 0, 0);

    // Partial frame abandoned by timeout
    send_bits(frame(8'h2A, 1'b1), 5);
    repeat (TMO + 40) @(posedge clk);
    key(8'h2A, 1, 8'h2A, 1, 4);
    check("timeout_no_err", {17'h0, frame_err}, 18'h0);
    key(8'hF0, 0, 8'h00, 0, 0);
    key(8'h2A, 1, 8'h2A, 0, 4);

    // Bad parity: only frame_err moves, later frames still accepted
    exp_ferr = 1'b1;
    exp_q.push_back(pack(8'h2A, 0, 4, 1'b1));
    send_bits(frame(8'h1C, 1'b0), 11);
    repeat (GAP) @(posedge clk);
    key(8'h1C, 1, 8'h1C, 1, 5);
    key(8'hF0, 0, 8'h00, 0, 0);
    key(8'h1C, 1, 8'h1C, 0, 5);

    // Reset mid-frame
    send_bits(frame(8'h55, 1'b1), 5);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_ferr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midframe_reset", cur, 18'h0);
    rst_n = 1'b1;
    repeat (TMO + 80) @(posedge clk);
    check("no_byte_after_reset", cur, 18'h0);

    // 100 make/break pairs: count runs 01..99 then wraps to 00
    for (int i = 0; i < 100; i++) begin
      key(8'(i + 1), 1, 8'(i + 1), 1, (i + 1) % 100);
      key(8'hF0, 0, 8'h00, 0, 0);
      key(8'(i + 1), 1, 8'(i + 1), 0, (i + 1) % 100);
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending required=0 pending", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
